// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring on magnitudes).
// Result lands in HI/LO 33 edges after Start is accepted; divide by zero completes at the next edge.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic        Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Done,
    output logic        DivZero,
    output logic [1:0]  o_state
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MULT   = 2'd1;
    localparam logic [1:0] DIV    = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    logic [1:0]  r_state;
    logic [5:0]  r_count;
    logic        r_op;
    logic        r_dz;
    logic        r_sign_a;
    logic        r_sign_b;
    logic [31:0] r_opnd;
    logic [32:0] r_acc_hi;
    logic [31:0] r_acc_lo;
    logic        r_booth;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;
    logic        r_divzero;

    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_mcand_ext;
    logic [32:0] w_booth_sum;
    logic [32:0] w_shifted;
    logic [33:0] w_trial;
    logic        w_fits;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_a_mag = A[31] ? (32'd0 - A) : A;
    assign w_b_mag = B[31] ? (32'd0 - B) : B;

    // Upper accumulator carries one guard bit so a -2^31 multiplicand cannot overflow.
    assign w_mcand_ext = {r_opnd[31], r_opnd};

    always_comb begin
        w_booth_sum = r_acc_hi;
        case ({r_acc_lo[0], r_booth})
            2'b01:   w_booth_sum = r_acc_hi + w_mcand_ext;
            2'b10:   w_booth_sum = r_acc_hi - w_mcand_ext;
            default: w_booth_sum = r_acc_hi;
        endcase
    end

    // Partial remainder stays below the divisor magnitude, so 32 bits hold it.
    assign w_shifted = {r_acc_hi[31:0], r_acc_lo[31]};
    assign w_trial   = {1'b0, w_shifted} - {2'b00, r_opnd};
    assign w_fits    = ~w_trial[33];

    assign w_quo_fix = (r_sign_a ^ r_sign_b) ? (32'd0 - r_acc_lo) : r_acc_lo;
    assign w_rem_fix = r_sign_a ? (32'd0 - r_acc_hi[31:0]) : r_acc_hi[31:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_count   <= 6'd0;
            r_op      <= 1'b0;
            r_dz      <= 1'b0;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_opnd    <= 32'd0;
            r_acc_hi  <= 33'd0;
            r_acc_lo  <= 32'd0;
            r_booth   <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_op     <= Op;
                        r_busy   <= 1'b1;
                        r_count  <= 6'd32;
                        r_sign_a <= A[31];
                        r_sign_b <= B[31];
                        r_acc_hi <= 33'd0;
                        r_booth  <= 1'b0;
                        if (!Op) begin
                            r_opnd   <= A;
                            r_acc_lo <= B;
                            r_dz     <= 1'b0;
                            r_state  <= MULT;
                        end else begin
                            r_opnd   <= w_b_mag;
                            r_acc_lo <= w_a_mag;
                            r_dz     <= (B == 32'd0);
                            r_state  <= (B == 32'd0) ? FINISH : DIV;
                        end
                    end
                end
                MULT: begin
                    r_acc_hi <= {w_booth_sum[32], w_booth_sum[32:1]};
                    r_acc_lo <= {w_booth_sum[0], r_acc_lo[31:1]};
                    r_booth  <= r_acc_lo[0];
                    r_count  <= r_count - 6'd1;
                    if (r_count == 6'd1) r_state <= FINISH;
                end
                DIV: begin
                    r_acc_hi <= w_fits ? {1'b0, w_trial[31:0]} : {1'b0, w_shifted[31:0]};
                    r_acc_lo <= {r_acc_lo[30:0], w_fits};
                    r_count  <= r_count - 6'd1;
                    if (r_count == 6'd1) r_state <= FINISH;
                end
                FINISH: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                    if (r_dz) begin
                        r_divzero <= 1'b1;
                    end else if (r_op) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= r_acc_hi[31:0];
                        r_lo <= r_acc_lo;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign HI      = r_hi;
    assign LO      = r_lo;
    assign Busy    = r_busy;
    assign Done    = r_done;
    assign DivZero = r_divzero;
    assign o_state = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against a plain-arithmetic model
// of signed 64-bit multiply and truncating signed divide.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic        Op;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        Done;
    logic        DivZero;
    logic [1:0]  dbg_state;

    mult_div_unit dut (
        .clk     (clk),
        .reset   (reset),
        .Start   (Start),
        .Op      (Op),
        .A       (A),
        .B       (B),
        .HI      (HI),
        .LO      (LO),
        .Busy    (Busy),
        .Done    (Done),
        .DivZero (DivZero),
        .o_state (dbg_state)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        e_dz;
    int          e_lat;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Expected result from signed arithmetic; HI/LO hold on divide by zero.
    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      res;
        logic [63:0] v;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op) begin
            res = sa * sb;
            v = res;
            e_hi = v[63:32];
            e_lo = v[31:0];
            e_dz = 1'b0;
            e_lat = 33;
        end else if (b == 32'd0) begin
            e_hi = m_hi;
            e_lo = m_lo;
            e_dz = 1'b1;
            e_lat = 1;
        end else begin
            res = sa / sb;
            v = res;
            e_lo = v[31:0];
            res = sa % sb;
            v = res;
            e_hi = v[31:0];
            e_dz = 1'b0;
            e_lat = 33;
        end
        exp_q.push_back({e_hi, e_lo});
        Start = 1'b1;
        Op = op;
        A = a;
        B = b;
    endtask

    task automatic complete(input string tag, input logic chain, input logic op2,
                            input logic [31:0] a2, input logic [31:0] b2);
        int          lat;
        logic        hold_ok;
        logic [63:0] expv;
        lat = -1;
        hold_ok = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (Done === 1'b1) begin
                lat = n;
                break;
            end
            if (!(Busy === 1'b1 && DivZero === 1'b0 && HI === m_hi && LO === m_lo)) hold_ok = 1'b0;
            Start = 1'($urandom_range(0, 1));
            Op = 1'($urandom_range(0, 1));
            A = $urandom;
            B = $urandom;
        end
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 64'd0;
        check({tag, " latency"}, 64'(lat), 64'(e_lat));
        check({tag, " busy_hold"}, 64'(hold_ok), 64'd1);
        check({tag, " HI"}, 64'(HI), 64'(expv[63:32]));
        check({tag, " LO"}, 64'(LO), 64'(expv[31:0]));
        check({tag, " DivZero"}, 64'(DivZero), 64'(e_dz));
        check({tag, " busy_low"}, 64'(Busy), 64'd0);
        m_hi = expv[63:32];
        m_lo = expv[31:0];
        if (chain) begin
            issue(op2, a2, b2);
        end else begin
            Start = 1'b0;
            @(negedge clk);
            check({tag, " done_width"}, 64'({Done, DivZero, Busy}), 64'd0);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic no_done;
        reset = 1'b1;
        Start = 1'b0;
        Op = 1'b0;
        A = 32'd0;
        B = 32'd0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (3) @(negedge clk);
        check("reset outputs", 64'({HI, LO, Busy, Done, DivZero}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(1'b0, 32'd7, 32'hFFFF_FFFD);
        complete("mul_7_m3", 1'b0, 1'b0, 32'd0, 32'd0);
        issue(1'b0, 32'h8000_0000, 32'h8000_0000);
        complete("mul_min_min", 1'b0, 1'b0, 32'd0, 32'd0);
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        complete("div_m7_2", 1'b0, 1'b0, 32'd0, 32'd0);
        issue(1'b1, 32'd5, 32'd0);
        complete("div_by_zero", 1'b0, 1'b0, 32'd0, 32'd0);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        complete("div_wrap", 1'b1, 1'b0, 32'd3, 32'd4);
        complete("mul_3_4_chained", 1'b0, 1'b0, 32'd0, 32'd0);

        // Abort mid-multiply: a second Start while busy, then asynchronous reset.
        Start = 1'b1;
        Op = 1'b0;
        A = $urandom;
        B = $urandom;
        no_done = 1'b1;
        for (int n = 0; n <= 10; n++) begin
            @(negedge clk);
            if (Done !== 1'b0) no_done = 1'b0;
            if (n == 4) begin
                Start = 1'b1;
                Op = 1'b1;
                A = $urandom;
                B = $urandom;
            end else begin
                Start = 1'b0;
            end
        end
        check("abort busy_before_reset", 64'(Busy), 64'd1);
        reset = 1'b1;
        #1;
        check("abort async_clear", 64'({HI, LO, Busy, Done, DivZero}), 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (Done !== 1'b0 || Busy !== 1'b0) no_done = 1'b0;
        end
        check("abort no_done", 64'(no_done), 64'd1);
        issue(1'b0, 32'd2, 32'd3);
        complete("mul_2_3_after_reset", 1'b0, 1'b0, 32'd0, 32'd0);

        for (int i = 0; i < 14; i++) begin
            logic        op;
            logic [31:0] a;
            logic [31:0] b;
            op = 1'($urandom_range(0, 1));
            a = pick_operand();
            b = pick_operand();
            issue(op, a, b);
            complete(op ? "rand_div" : "rand_mul", 1'b0, 1'b0, 32'd0, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
